// File: rtl/mem_bus_pkg.sv
// Shared definitions for the memory read-channel arbiter: FSM encoding,
// grant IDs and default bus widths.
package mem_bus_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  localparam int LEN_W_DEF  = 8;

  typedef enum logic [2:0] {
    S_IDLE = 3'b001,
    S_REQ  = 3'b010,
    S_RSP  = 3'b100
  } state_t;

  localparam logic GNT_IC = 1'b0;
  localparam logic GNT_DC = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter. Bit 0 is the I-cache, bit 1 the D-cache.
// The pointer holds the last granted ID; a tie goes to the other master.
module rr_arb2
  import mem_bus_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_req,
  input  logic       i_upd,
  input  logic       i_upd_id,
  output logic [1:0] o_gnt
);

  logic r_last_id;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_last_id <= GNT_IC;
    end else if (i_upd) begin
      r_last_id <= i_upd_id;
    end
  end

  always_comb begin
    o_gnt = 2'b00;
    case (i_req)
      2'b01:   o_gnt = 2'b01;
      2'b10:   o_gnt = 2'b10;
      2'b11:   o_gnt = (r_last_id == GNT_IC) ? 2'b10 : 2'b01;
      default: o_gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_rd_arbiter.sv
// Serialises I-cache / D-cache read transactions onto one memory read port.
// state  | meaning
// S_IDLE | arbitrate; winner's request latched on handshake
// S_REQ  | latched request presented to memory until accepted
// S_RSP  | beats passed through to the granted master until last
module mem_rd_arbiter
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              from_ic_rd_req_valid,
  input  logic [ADDR_W-1:0] from_ic_rd_req_addr,
  input  logic [LEN_W-1:0]  from_ic_rd_req_len,
  output logic              to_ic_rd_req_ready,
  output logic              to_ic_rd_rsp_valid,
  output logic [DATA_W-1:0] to_ic_rd_rsp_data,
  output logic              to_ic_rd_rsp_last,
  input  logic              from_ic_rd_rsp_ready,
  input  logic              from_dc_rd_req_valid,
  input  logic [ADDR_W-1:0] from_dc_rd_req_addr,
  input  logic [LEN_W-1:0]  from_dc_rd_req_len,
  output logic              to_dc_rd_req_ready,
  output logic              to_dc_rd_rsp_valid,
  output logic [DATA_W-1:0] to_dc_rd_rsp_data,
  output logic              to_dc_rd_rsp_last,
  input  logic              from_dc_rd_rsp_ready,
  output logic              to_mem_rd_req_valid,
  output logic [ADDR_W-1:0] to_mem_rd_req_addr,
  output logic [LEN_W-1:0]  to_mem_rd_req_len,
  input  logic              from_mem_rd_req_ready,
  input  logic              from_mem_rd_rsp_valid,
  input  logic [DATA_W-1:0] from_mem_rd_rsp_data,
  input  logic              from_mem_rd_rsp_last,
  output logic              to_mem_rd_rsp_ready,
  output logic              len_err
);

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [LEN_W-1:0]  r_len;
  logic              r_gnt_id;
  logic [LEN_W:0]    r_beat_cnt;
  logic              r_len_err;

  logic [1:0] w_gnt;
  logic       w_req_hs;
  logic       w_mem_req_hs;
  logic       w_rsp_hs;
  logic       w_done;
  logic       w_sel_rdy;
  logic       w_cnt_eq_len;

  rr_arb2 u_rr_arb2 (
    .clk      (clk),
    .rst      (rst),
    .i_req    ({from_dc_rd_req_valid, from_ic_rd_req_valid}),
    .i_upd    (w_done),
    .i_upd_id (r_gnt_id),
    .o_gnt    (w_gnt)
  );

  assign w_cnt_eq_len       = (r_beat_cnt == {1'b0, r_len});
  assign to_mem_rd_req_addr = r_addr;
  assign to_mem_rd_req_len  = r_len;
  assign len_err            = r_len_err;

  always_comb begin
    w_state_nxt         = r_state;
    w_req_hs            = 1'b0;
    w_mem_req_hs        = 1'b0;
    w_rsp_hs            = 1'b0;
    w_done              = 1'b0;
    w_sel_rdy           = 1'b0;
    to_ic_rd_req_ready  = 1'b0;
    to_dc_rd_req_ready  = 1'b0;
    to_ic_rd_rsp_valid  = 1'b0;
    to_ic_rd_rsp_data   = '0;
    to_ic_rd_rsp_last   = 1'b0;
    to_dc_rd_rsp_valid  = 1'b0;
    to_dc_rd_rsp_data   = '0;
    to_dc_rd_rsp_last   = 1'b0;
    to_mem_rd_req_valid = 1'b0;
    to_mem_rd_rsp_ready = 1'b0;
    case (r_state)
      S_IDLE: begin
        // no handshake while reset is asserted: it would be discarded anyway
        if (rst && (w_gnt != 2'b00)) begin
          to_ic_rd_req_ready = w_gnt[0];
          to_dc_rd_req_ready = w_gnt[1];
          w_req_hs           = 1'b1;
          w_state_nxt        = S_REQ;
        end
      end
      S_REQ: begin
        to_mem_rd_req_valid = 1'b1;
        if (from_mem_rd_req_ready) begin
          w_mem_req_hs = 1'b1;
          w_state_nxt  = S_RSP;
        end
      end
      S_RSP: begin
        w_sel_rdy           = (r_gnt_id == GNT_DC) ? from_dc_rd_rsp_ready : from_ic_rd_rsp_ready;
        to_mem_rd_rsp_ready = w_sel_rdy;
        if (r_gnt_id == GNT_DC) begin
          to_dc_rd_rsp_valid = from_mem_rd_rsp_valid;
          to_dc_rd_rsp_data  = from_mem_rd_rsp_data;
          to_dc_rd_rsp_last  = from_mem_rd_rsp_last;
        end else begin
          to_ic_rd_rsp_valid = from_mem_rd_rsp_valid;
          to_ic_rd_rsp_data  = from_mem_rd_rsp_data;
          to_ic_rd_rsp_last  = from_mem_rd_rsp_last;
        end
        w_rsp_hs = from_mem_rd_rsp_valid & w_sel_rdy;
        if (w_rsp_hs && from_mem_rd_rsp_last) begin
          w_done      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_len      <= '0;
      r_gnt_id   <= GNT_IC;
      r_beat_cnt <= '0;
      r_len_err  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_req_hs) begin
        r_addr   <= w_gnt[1] ? from_dc_rd_req_addr : from_ic_rd_req_addr;
        r_len    <= w_gnt[1] ? from_dc_rd_req_len : from_ic_rd_req_len;
        r_gnt_id <= w_gnt[1];
      end
      if (w_mem_req_hs) begin
        r_beat_cnt <= '0;
      end else if (w_rsp_hs && (r_beat_cnt != '1)) begin
        r_beat_cnt <= r_beat_cnt + {{LEN_W{1'b0}}, 1'b1};
      end
      // count reached len must coincide exactly with the last beat
      if (w_rsp_hs && (from_mem_rd_rsp_last != w_cnt_eq_len)) begin
        r_len_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_rd_arbiter.sv
// Directed + randomised bench for mem_rd_arbiter against a transaction-level
// model (round-robin winner, sticky beat-count error).
module tb_mem_rd_arbiter;
  import mem_bus_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        ic_v, dc_v, ic_rdy, dc_rdy;
  logic [31:0] ic_addr, dc_addr;
  logic [7:0]  ic_len, dc_len;
  logic        to_ic_req_rdy, to_dc_req_rdy;
  logic        to_ic_v, to_dc_v, to_ic_last, to_dc_last;
  logic [31:0] to_ic_data, to_dc_data;
  logic        mem_req_v, mem_req_rdy, mem_rsp_v, mem_rsp_last, mem_rsp_rdy;
  logic [31:0] mem_addr, mem_data;
  logic [7:0]  mem_len;
  logic        len_err;

  int checks = 0;
  int errors = 0;
  bit m_last_dc;
  bit m_err;

  always #5 clk = ~clk;

  mem_rd_arbiter dut (
    .clk(clk), .rst(rst),
    .from_ic_rd_req_valid(ic_v), .from_ic_rd_req_addr(ic_addr), .from_ic_rd_req_len(ic_len),
    .to_ic_rd_req_ready(to_ic_req_rdy), .to_ic_rd_rsp_valid(to_ic_v), .to_ic_rd_rsp_data(to_ic_data),
    .to_ic_rd_rsp_last(to_ic_last), .from_ic_rd_rsp_ready(ic_rdy),
    .from_dc_rd_req_valid(dc_v), .from_dc_rd_req_addr(dc_addr), .from_dc_rd_req_len(dc_len),
    .to_dc_rd_req_ready(to_dc_req_rdy), .to_dc_rd_rsp_valid(to_dc_v), .to_dc_rd_rsp_data(to_dc_data),
    .to_dc_rd_rsp_last(to_dc_last), .from_dc_rd_rsp_ready(dc_rdy),
    .to_mem_rd_req_valid(mem_req_v), .to_mem_rd_req_addr(mem_addr), .to_mem_rd_req_len(mem_len),
    .from_mem_rd_req_ready(mem_req_rdy), .from_mem_rd_rsp_valid(mem_rsp_v),
    .from_mem_rd_rsp_data(mem_data), .from_mem_rd_rsp_last(mem_rsp_last),
    .to_mem_rd_rsp_ready(mem_rsp_rdy), .len_err(len_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Tie goes to whoever was not granted last; otherwise the sole requester.
  function automatic bit winner_dc(input bit iv, input bit dv);
    if (iv && dv) return !m_last_dc;
    return dv;
  endfunction

  task automatic all_zero(input string tag);
    chk({tag, "_ic_req_rdy"}, to_ic_req_rdy, 0);
    chk({tag, "_dc_req_rdy"}, to_dc_req_rdy, 0);
    chk({tag, "_ic_rsp"}, {to_ic_v, to_ic_last, to_ic_data}, 0);
    chk({tag, "_dc_rsp"}, {to_dc_v, to_dc_last, to_dc_data}, 0);
    chk({tag, "_mem_req"}, {mem_req_v, mem_addr, mem_len}, 0);
    chk({tag, "_mem_rsp_rdy"}, mem_rsp_rdy, 0);
    chk({tag, "_len_err"}, len_err, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    m_last_dc = 1'b0;
    m_err     = 1'b0;
  endtask

  // Entered just after a negedge with request valids already driven.
  // bp_mode: 0 always ready, 1 stall once on beats 2..4, 2 random ready.
  task automatic txn(input int nb_delta, input int stall, input int bp_mode,
                     input int rst_at, input bit seq_data);
    bit          w;
    logic [31:0] a, d;
    logic [7:0]  l;
    int          nb, i, guard;
    bit          rdy, held;
    #1;
    w = winner_dc(ic_v, dc_v);
    a = w ? dc_addr : ic_addr;
    l = w ? dc_len : ic_len;
    nb = int'(l) + 1 + nb_delta;
    if (nb < 1) nb = 1;
    chk("req_ready_winner", w ? to_dc_req_rdy : to_ic_req_rdy, 1);
    chk("req_ready_loser", w ? to_ic_req_rdy : to_dc_req_rdy, 0);
    chk("mem_valid_in_idle", mem_req_v, 0);
    @(negedge clk);
    if (w) dc_v = 1'b0; else ic_v = 1'b0;
    #1;
    chk("mem_valid_1cyc", mem_req_v, 1);
    chk("mem_addr", mem_addr, a);
    chk("mem_len", mem_len, l);
    chk("busy_ready", to_ic_req_rdy | to_dc_req_rdy, 0);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      #1;
      chk("stall_valid", mem_req_v, 1);
      chk("stall_addr", mem_addr, a);
      chk("stall_len", mem_len, l);
      chk("stall_busy_ready", to_ic_req_rdy | to_dc_req_rdy, 0);
    end
    mem_req_rdy = 1'b1;
    @(negedge clk);
    mem_req_rdy = 1'b0;
    i = 0; guard = 0; held = 1'b0; d = '0;
    while (i < nb && guard < 400) begin
      guard++;
      if (!held) d = seq_data ? 32'hA0 + 32'(i) : $urandom;
      rdy = 1'b1;
      if (bp_mode == 1) rdy = !(i >= 1 && i <= 3 && !held);
      if (bp_mode == 2) rdy = 1'($urandom_range(0, 1));
      mem_rsp_v    = 1'b1;
      mem_data     = d;
      mem_rsp_last = (i == nb - 1);
      if (w) begin dc_rdy = rdy; ic_rdy = 1'($urandom_range(0, 1)); end
      else   begin ic_rdy = rdy; dc_rdy = 1'($urandom_range(0, 1)); end
      if (rst_at == i) rst = 1'b0;
      #1;
      chk("rsp_valid", w ? to_dc_v : to_ic_v, 1);
      chk("rsp_data", w ? to_dc_data : to_ic_data, d);
      chk("rsp_last", w ? to_dc_last : to_ic_last, (i == nb - 1));
      chk("rsp_other_valid", w ? to_ic_v : to_dc_v, 0);
      chk("mem_rsp_ready", mem_rsp_rdy, rdy);
      chk("mem_req_valid_in_rsp", mem_req_v, 0);
      if (rst_at == i) begin
        @(negedge clk);
        rst = 1'b1;
        mem_rsp_v = 1'b0; mem_rsp_last = 1'b0; mem_data = '0;
        ic_rdy = 1'b0; dc_rdy = 1'b0;
        #1;
        all_zero("post_reset");
        m_last_dc = 1'b0;
        m_err     = 1'b0;
        return;
      end
      if (rdy) begin i++; held = 1'b0; end else held = 1'b1;
      @(negedge clk);
    end
    chk("beat_budget", (guard < 400), 1);
    mem_rsp_v = 1'b0; mem_rsp_last = 1'b0; mem_data = '0;
    ic_rdy = 1'b0; dc_rdy = 1'b0;
    m_err     = m_err | (nb != int'(l) + 1);
    m_last_dc = w;
    #1;
    chk("end_mem_valid", mem_req_v, 0);
    chk("end_rsp_valid", {to_ic_v, to_dc_v, mem_rsp_rdy}, 0);
    chk("len_err", len_err, m_err);
  endtask

  initial begin
    rst = 1'b0;
    ic_v = 0; dc_v = 0; ic_rdy = 0; dc_rdy = 0;
    ic_addr = '0; dc_addr = '0; ic_len = '0; dc_len = '0;
    mem_req_rdy = 0; mem_rsp_v = 0; mem_rsp_last = 0; mem_data = '0;
    m_last_dc = 1'b0; m_err = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    all_zero("reset");
    @(negedge clk);
    rst = 1'b1;

    // single D-cache read, 8 sequential beats
    @(negedge clk);
    dc_v = 1; dc_addr = 32'h0000_1000; dc_len = 8'd7;
    txn(0, 0, 0, -1, 1'b1);

    // tie after reset: D-cache, then I-cache back-to-back, then D-cache again
    do_reset();
    ic_v = 1; ic_addr = 32'h100; ic_len = 8'd7;
    dc_v = 1; dc_addr = 32'h200; dc_len = 8'd0;
    txn(0, 0, 0, -1, 1'b0);
    txn(0, 0, 0, -1, 1'b0);

    // tie with memory request backpressure; I-cache waits while busy
    ic_v = 1; ic_addr = 32'h300; ic_len = 8'd7;
    dc_v = 1; dc_addr = 32'h400; dc_len = 8'd3;
    txn(0, 5, 0, -1, 1'b0);
    // the waiting I-cache request, with response backpressure on beats 2..4
    txn(0, 0, 1, -1, 1'b0);

    // length mismatch: last on beat 4 of a len-7 burst, then sticky
    ic_v = 1; ic_addr = 32'h500; ic_len = 8'd7;
    txn(-4, 0, 0, -1, 1'b0);
    dc_v = 1; dc_addr = 32'h600; dc_len = 8'd2;
    txn(0, 1, 2, -1, 1'b0);

    for (int k = 0; k < 10; k++) begin
      int r, dlt;
      r = $urandom_range(1, 3);
      ic_v = r[0]; dc_v = r[1];
      ic_addr = $urandom; dc_addr = $urandom;
      ic_len = 8'($urandom_range(0, 4)); dc_len = 8'($urandom_range(0, 4));
      dlt = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 1) ? 1 : -1) : 0;
      txn(dlt, $urandom_range(0, 2), 2, -1, 1'b0);
      ic_v = 0; dc_v = 0;
    end

    // reset at beat 3 of a burst, then a fresh request is served normally
    ic_v = 1; ic_addr = 32'h700; ic_len = 8'd7;
    txn(0, 0, 0, 2, 1'b0);
    ic_v = 1; ic_addr = 32'h800; ic_len = 8'd1;
    txn(0, 0, 0, -1, 1'b0);

    // pointer restored by reset: next tie goes to the D-cache... after I-cache grant it's D-cache anyway; check a tie again
    ic_v = 1; ic_addr = 32'h900; ic_len = 8'd0;
    dc_v = 1; dc_addr = 32'hA00; dc_len = 8'd0;
    txn(0, 0, 0, -1, 1'b0);
    txn(0, 0, 0, -1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_rd_arbiter.md
Name: mem_rd_arbiter

Overview:
- Two-master, one-slave arbiter for the memory read channel. It sits directly downstream of the I-cache and the D-cache and upstream of the shared memory/IO read port.
- Serialises whole read transactions, one at a time. A transaction is one request followed by all of its response beats.
- Grant policy is round-robin. Each request is registered before it is forwarded to memory.
- A beat counter checks that the number of response beats matches the requested length.

Parameters:
- ADDR_W, 32, request address width
- DATA_W, 32, response data width
- LEN_W, 8, burst length field width (len = beats - 1)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset (rst==0 resets on posedge clk)
- from_ic_rd_req_valid  in  1  I-cache read request valid
- from_ic_rd_req_addr  in  ADDR_W  I-cache request address
- from_ic_rd_req_len  in  LEN_W  I-cache burst length
- to_ic_rd_req_ready  out  1  request accepted from I-cache
- to_ic_rd_rsp_valid  out  1  beat valid to I-cache
- to_ic_rd_rsp_data  out  DATA_W  beat data to I-cache
- to_ic_rd_rsp_last  out  1  last beat to I-cache
- from_ic_rd_rsp_ready  in  1  I-cache accepts beat
- from_dc_rd_req_valid, from_dc_rd_req_addr, from_dc_rd_req_len, to_dc_rd_req_ready, to_dc_rd_rsp_valid, to_dc_rd_rsp_data, to_dc_rd_rsp_last, from_dc_rd_rsp_ready: same as the I-cache ports, for the D-cache
- to_mem_rd_req_valid  out  1  request valid to memory
- to_mem_rd_req_addr  out  ADDR_W  latched address
- to_mem_rd_req_len  out  LEN_W  latched length
- from_mem_rd_req_ready  in  1  memory accepts request
- from_mem_rd_rsp_valid  in  1  memory beat valid
- from_mem_rd_rsp_data  in  DATA_W  memory beat data
- from_mem_rd_rsp_last  in  1  memory last beat
- to_mem_rd_rsp_ready  out  1  beat accepted
- len_err  out  1  sticky: beat-count mismatch seen

Behaviour:
- States are one-hot: S_IDLE, S_REQ, S_RSP. Reset state is S_IDLE.

Reset:
- Reset clears every output to 0, sets the priority pointer to I-cache, clears the beat counter and clears len_err.
- Reset during S_REQ or S_RSP abandons the transaction immediately. No drain is performed.

S_IDLE:
- If exactly one master has valid high, that master is granted.
- If both have valid high, the master not granted last time wins. After reset the D-cache wins the first tie, because the pointer marks the I-cache as last granted.
- to_X_rd_req_ready is high combinationally in S_IDLE for the winner only, in the same cycle as its valid. Ready is never high without a matching valid.
- On that handshake the block latches addr, len and grant_id. Next state is S_REQ.
- With no valid request, the block stays in S_IDLE.

S_REQ:
- to_mem_rd_req_valid = 1, driving the latched addr and len. These hold stable until from_mem_rd_req_ready.
- On from_mem_rd_req_ready, the beat counter is loaded with 0 and the next state is S_RSP.
- Minimum request latency: 1 cycle from the upstream handshake to mem valid.

S_RSP:
- Combinational pass-through in both directions.
  - to_G_rd_rsp_valid/data/last = from_mem_rd_rsp_*.
  - to_mem_rd_rsp_ready = from_G_rd_rsp_ready.
  - The non-granted master sees valid = 0.
- Each beat handshake (valid & ready) increments the beat counter. The counter is LEN_W+1 bits wide and saturates at all-ones.
- A handshake with last = 1 ends the transaction:
  - Next state is S_IDLE and the priority pointer records grant_id.
  - If counter ≠ latched len on that beat, len_err is set.
- A beat with last = 0 when counter == len also sets len_err. The transaction continues until last arrives.
- Outside S_RSP, to_mem_rd_rsp_ready = 0 and both to_X_rd_rsp_valid = 0.

Timing rules:
- The earliest new arbitration is the cycle after the last beat. There is no overlap between transactions.
- Requests arriving while busy wait: their ready stays 0.

Decomposition:
- Shared package mem_bus_pkg holds:
  - the one-hot state constants S_IDLE, S_REQ, S_RSP;
  - the grant ID constants GNT_IC = 0 and GNT_DC = 1;
  - the default widths.
- One sub-module, rr_arb2: a 2-input round-robin arbiter with a priority pointer, which outputs the grant vector combinationally. All other logic is inline.

Test Plan:
1. Single D-cache read: addr 0x0000_1000, len 7, 8 beats 0xA0..0xA7.
   - mem sees valid 1 cycle after the D-cache handshake.
   - The D-cache receives 8 beats, last on the 8th; the I-cache sees no valid.
   - The FSM returns to S_IDLE; len_err = 0.
2. Simultaneous I-cache (0x100, len 7) and D-cache (0x200, len 0) after reset.
   - D-cache is granted first and its 1 beat completes.
   - The I-cache is then granted with no idle gap beyond one S_IDLE cycle.
   - Next tie → the D-cache wins again, because the I-cache was granted last.
3. Memory backpressure: from_mem_rd_req_ready held low 5 cycles.
   - to_mem_rd_req_addr/len are stable for all 6 cycles.
   - No upstream ready is asserted during S_REQ.
4. Response backpressure: the I-cache drops rsp_ready on beats 2–4 of a len-7 burst.
   - to_mem_rd_rsp_ready follows it.
   - Beats are neither lost nor duplicated; the data sequence is intact.
5. Length mismatch: len 7 request, memory asserts last on beat 4.
   - Transaction ends, len_err = 1 and stays 1 until reset.
6. Reset mid-S_RSP: rst = 0 for 1 cycle at beat 3.
   - All outputs are 0 in the next cycle and the FSM is in S_IDLE.
   - A new I-cache request is accepted normally.
